// File: rtl/tx_framer_pkg.sv
// tx_framer shared definitions.
// Frame constants, FSM state encoding and the payload length clamp.
package tx_framer_pkg;

    localparam logic [15:0] SYNC_WORD     = 16'h2DD4;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;
    localparam logic [15:0] CRC_POLY      = 16'h1021;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam int          MSG_RAM_SIZE  = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SYNC,
        ST_LEN,
        ST_PAYLOAD,
        ST_CRC,
        ST_DONE,
        ST_CW
    } state_e;

    function automatic logic [9:0] clamp_len(
        input logic [9:0] len,
        input logic [9:0] max_len
    );
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/tx_framer_if.sv
// Framer bus: message RAM read port and modulator bit handshake.
// master = framer side, slave = RAM/modulator side.
interface tx_framer_if;

    logic       o_ram_rd_en;
    logic [9:0] o_ram_rd_addr;
    logic [7:0] i_ram_rd_data;
    logic       i_bit_strobe;
    logic       o_bit;
    logic       o_bit_valid;

    modport master (
        output o_ram_rd_en,
        output o_ram_rd_addr,
        input  i_ram_rd_data,
        input  i_bit_strobe,
        output o_bit,
        output o_bit_valid
    );

    modport slave (
        input  o_ram_rd_en,
        input  o_ram_rd_addr,
        output i_ram_rd_data,
        output i_bit_strobe,
        input  o_bit,
        input  o_bit_valid
    );

endinterface

// File: rtl/tx_framer_crc.sv
// Bit-serial CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF).
// init restarts the register; en shifts bit_in into it.
module crc16_ccitt_serial
    import tx_framer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb;

    // Next CRC value: restart on init, else fold one data bit in
    always_comb begin
        fb    = crc_q[15] ^ bit_in;
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
    end

    // CRC register
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/tx_framer.sv
// Frame transmitter: preamble, sync, length, payload from RAM, CRC-16.
// Serialised MSB-first under the modulator bit strobe; CW test mode.
module tx_framer
    import tx_framer_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 4,
    parameter int MAX_LEN        = MSG_RAM_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_transmit,
    input  logic [9:0]  i_msg_length,
    input  logic        i_cw,
    tx_framer_if.master bus,
    output logic        o_busy,
    output logic        o_tx_done
);

    state_e      state_q, state_d;
    logic        armed_q, armed_d;
    logic [9:0]  len_q, len_d;
    logic [15:0] sh_q, sh_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  pre_q, pre_d;
    logic [9:0]  idx_q, idx_d;
    logic [9:0]  addr_q, addr_d;
    logic        rd_en_q, rd_en_d;
    logic        rd_pend_q, rd_pend_d;
    logic [7:0]  buf_q, buf_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        take;
    logic        last;
    logic        crc_init;
    logic        crc_en;
    logic [15:0] crc_val;

    crc16_ccitt_serial u_crc (
        .clk    (clk),
        .reset  (reset),
        .init   (crc_init),
        .en     (crc_en),
        .bit_in (sh_q[15]),
        .crc    (crc_val)
    );

    // Next-state logic: FSM, bit counters, shifter and prefetch buffer
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q | ~i_transmit;
        len_d     = len_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        pre_d     = pre_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        rd_en_d   = 1'b0;
        rd_pend_d = rd_en_q;
        buf_d     = buf_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        crc_init  = 1'b0;
        take      = bus.i_bit_strobe & valid_q;
        last      = take & (cnt_q == 5'd1);
        crc_en    = take & (state_q == ST_PAYLOAD);

        if (rd_pend_q) begin
            buf_d = bus.i_ram_rd_data;
        end

        if (take) begin
            sh_d  = {sh_q[14:0], 1'b0};
            cnt_d = cnt_q - 5'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                sh_d    = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (i_cw) begin
                    state_d = ST_CW;
                    sh_d    = '1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (i_transmit && armed_q) begin
                    state_d  = ST_PREAMBLE;
                    armed_d  = 1'b0;
                    len_d    = clamp_len(i_msg_length, 10'(MAX_LEN));
                    sh_d     = {PREAMBLE_BYTE, 8'h00};
                    cnt_d    = 5'd8;
                    pre_d    = 4'(PREAMBLE_BYTES - 1);
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    crc_init = 1'b1;
                end
            end
            ST_CW: begin
                sh_d = '1;
                if (!i_cw) begin
                    state_d = ST_IDLE;
                    sh_d    = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            ST_PREAMBLE: begin
                if (last) begin
                    if (pre_q != 4'd0) begin
                        sh_d  = {PREAMBLE_BYTE, 8'h00};
                        cnt_d = 5'd8;
                        pre_d = pre_q - 4'd1;
                    end else begin
                        state_d = ST_SYNC;
                        sh_d    = SYNC_WORD;
                        cnt_d   = 5'd16;
                    end
                end
            end
            ST_SYNC: begin
                if (last) begin
                    state_d = ST_LEN;
                    sh_d    = {6'b0, len_q};
                    cnt_d   = 5'd16;
                    if (len_q != 10'd0) begin
                        rd_en_d = 1'b1;
                        addr_d  = 10'd0;
                    end
                end
            end
            ST_LEN: begin
                if (last) begin
                    if (len_q == 10'd0) begin
                        state_d = ST_CRC;
                        sh_d    = '0;
                        valid_d = 1'b0;
                    end else begin
                        state_d = ST_PAYLOAD;
                        sh_d    = {buf_q, 8'h00};
                        cnt_d   = 5'd8;
                        idx_d   = 10'd0;
                        if (len_q > 10'd1) begin
                            rd_en_d = 1'b1;
                            addr_d  = 10'd1;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (last) begin
                    if (idx_q == len_q - 10'd1) begin
                        // one idle cycle lets the last CRC update settle
                        state_d = ST_CRC;
                        sh_d    = '0;
                        valid_d = 1'b0;
                    end else begin
                        sh_d  = {buf_q, 8'h00};
                        cnt_d = 5'd8;
                        idx_d = idx_q + 10'd1;
                        if (({1'b0, idx_q} + 11'd2) < {1'b0, len_q}) begin
                            rd_en_d = 1'b1;
                            addr_d  = idx_q + 10'd2;
                        end
                    end
                end
            end
            ST_CRC: begin
                if (!valid_q) begin
                    sh_d    = crc_val;
                    cnt_d   = 5'd16;
                    valid_d = 1'b1;
                end else if (last) begin
                    state_d = ST_DONE;
                    sh_d    = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                sh_d    = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b1;
            len_q     <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            pre_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            buf_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            len_q     <= len_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            rd_pend_q <= rd_pend_d;
            buf_q     <= buf_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_ram_rd_en   = rd_en_q;
    assign bus.o_ram_rd_addr = addr_q;
    assign bus.o_bit         = sh_q[15];
    assign bus.o_bit_valid   = valid_q;
    assign o_busy            = busy_q;
    assign o_tx_done         = done_q;

endmodule
